// File: rtl/amt_commit_repair_pkg.sv
// Shared constants and types for the architectural map table and its repair streamer.
package amt_commit_repair_pkg;

    localparam int COMMIT_WIDTH      = 4;
    localparam int N_REPAIR_PACKETS  = 4;
    localparam int SIZE_RMT          = 34;
    localparam int SIZE_RMT_LOG      = 6;
    localparam int SIZE_PHYSICAL_LOG = 7;

    localparam int N_BEATS = (SIZE_RMT + N_REPAIR_PACKETS - 1) / N_REPAIR_PACKETS;
    localparam int BEAT_W  = $clog2(N_BEATS);

    // Packed as {valid, reg_id} to match the free-list interface.
    typedef struct packed {
        logic                         valid;
        logic [SIZE_PHYSICAL_LOG-1:0] reg_id;
    } phys_reg_t;

    typedef enum logic {
        IDLE,
        REPAIR
    } repair_state_t;

endpackage

// File: rtl/amt_commit_repair_amt_ram.sv
// Committed logical-to-physical map: flop array, multi-port write (youngest lane wins),
// asynchronous reads for commit bypass and repair streaming.
module amt_ram
    import amt_commit_repair_pkg::*;
(
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [COMMIT_WIDTH-1:0]                             we_i,
    input  logic [COMMIT_WIDTH*SIZE_RMT_LOG-1:0]                waddr_i,
    input  logic [COMMIT_WIDTH*SIZE_PHYSICAL_LOG-1:0]           wdata_i,
    input  logic [(COMMIT_WIDTH+N_REPAIR_PACKETS)*SIZE_RMT_LOG-1:0]      raddr_i,
    output logic [(COMMIT_WIDTH+N_REPAIR_PACKETS)*SIZE_PHYSICAL_LOG-1:0] rdata_o
);

    localparam int N_RD = COMMIT_WIDTH + N_REPAIR_PACKETS;

    logic [SIZE_PHYSICAL_LOG-1:0] mem_q [SIZE_RMT];
    logic [SIZE_PHYSICAL_LOG-1:0] mem_d [SIZE_RMT];

    always_comb begin
        mem_d = mem_q;
        // Later lanes overwrite earlier ones, so the youngest write to an entry sticks.
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (we_i[k] && waddr_i[k*SIZE_RMT_LOG +: SIZE_RMT_LOG] < SIZE_RMT_LOG'(SIZE_RMT)) begin
                mem_d[waddr_i[k*SIZE_RMT_LOG +: SIZE_RMT_LOG]] = wdata_i[k*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned r = 0; r < N_RD; r++) begin
            if (raddr_i[r*SIZE_RMT_LOG +: SIZE_RMT_LOG] < SIZE_RMT_LOG'(SIZE_RMT)) begin
                rdata_o[r*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG] = mem_q[raddr_i[r*SIZE_RMT_LOG +: SIZE_RMT_LOG]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SIZE_RMT; i++) begin
                mem_q[i] <= SIZE_PHYSICAL_LOG'(i);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/amt_commit_repair.sv
// Commit-side map table: frees the previous mapping on retire and, after a recover,
// streams the committed map back to rename as repair packets.
module amt_commit_repair
    import amt_commit_repair_pkg::*;
(
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [COMMIT_WIDTH-1:0]                         commitValid_i,
    input  logic [COMMIT_WIDTH*SIZE_RMT_LOG-1:0]            commitLogDest_i,
    input  logic [COMMIT_WIDTH*SIZE_PHYSICAL_LOG-1:0]       commitPhyDest_i,
    input  logic                                            recoverFlag_i,
    output logic [COMMIT_WIDTH*(SIZE_PHYSICAL_LOG+1)-1:0]   freedPhyReg_o,
    output logic                                            repairFlag_o,
    output logic [N_REPAIR_PACKETS*SIZE_RMT_LOG-1:0]        repairAddr_o,
    output logic [N_REPAIR_PACKETS*SIZE_PHYSICAL_LOG-1:0]   repairData_o,
    output logic                                            busy_o
);

    localparam int N_RD = COMMIT_WIDTH + N_REPAIR_PACKETS;

    logic [COMMIT_WIDTH-1:0][SIZE_RMT_LOG-1:0]      log_dest;
    logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] phy_dest;
    logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] old_map;
    logic [N_RD-1:0][SIZE_RMT_LOG-1:0]              rd_addr;
    logic [N_RD-1:0][SIZE_PHYSICAL_LOG-1:0]         rd_data;
    logic [COMMIT_WIDTH-1:0]                        commit_en;
    logic [SIZE_RMT_LOG:0]                          addr_wide;

    repair_state_t                  state_q, state_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    phys_reg_t [COMMIT_WIDTH-1:0]   freed_q, freed_d;

    assign log_dest  = commitLogDest_i;
    assign phy_dest  = commitPhyDest_i;
    assign commit_en = (state_q == IDLE) ? commitValid_i : '0;

    amt_ram u_amt_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (commit_en),
        .waddr_i (log_dest),
        .wdata_i (phy_dest),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        rd_addr   = '0;
        old_map   = '0;
        addr_wide = '0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            rd_addr[k] = log_dest[k];
            old_map[k] = rd_data[k];
            // An older lane in the same group writing this logDest supersedes the AMT entry.
            for (int unsigned j = 0; j < k; j++) begin
                if (commitValid_i[j] && log_dest[j] == log_dest[k]) begin
                    old_map[k] = phy_dest[j];
                end
            end
        end
        for (int unsigned p = 0; p < N_REPAIR_PACKETS; p++) begin
            addr_wide = (SIZE_RMT_LOG+1)'(int'(beat_q) * N_REPAIR_PACKETS + int'(p));
            rd_addr[COMMIT_WIDTH+p] = (addr_wide >= (SIZE_RMT_LOG+1)'(SIZE_RMT))
                                    ? SIZE_RMT_LOG'(SIZE_RMT - 1)
                                    : addr_wide[SIZE_RMT_LOG-1:0];
        end
    end

    always_comb begin
        freed_d = '0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            freed_d[k].valid  = commit_en[k];
            freed_d[k].reg_id = commit_en[k] ? old_map[k] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (state_q == IDLE) begin
            if (recoverFlag_i) begin
                state_d = REPAIR;
                beat_d  = '0;
            end
        end else if (recoverFlag_i) begin
            beat_d = '0;
        end else if (beat_q == BEAT_W'(N_BEATS - 1)) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            freed_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            freed_q <= freed_d;
        end
    end

    assign freedPhyReg_o = freed_q;
    assign repairFlag_o  = (state_q == REPAIR);
    assign busy_o        = (state_q == REPAIR);
    assign repairAddr_o  = rd_addr[N_RD-1:COMMIT_WIDTH];
    assign repairData_o  = rd_data[N_RD-1:COMMIT_WIDTH];

    // Retire must be stalled while the rename table is being repaired.
    assert property (@(posedge clk) disable iff (!reset)
                     !(state_q == REPAIR && |commitValid_i))
        else $error("commit while repair in progress");

endmodule
